// File: rtl/assoc_cache_ctrl.sv
// Two-way set-associative write-back, write-allocate cache controller.
// Pseudo-LRU per set, word-wide burst memory port, hit/miss/wb stats.
module assoc_cache_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr_req,
   input  logic [DATA_W-1:0] data_wr,
   output logic [DATA_W-1:0] data_rd,
   output logic [ADDR_W-1:0] addr_resp,
   output logic              rdy,
   output logic              busy,
   output logic              rd_mem,
   output logic              wr_mem,
   input  logic              busy_mem,
   output logic [ADDR_W-1:0] addr_mem,
   output logic [DATA_W-1:0] data_wr_mem,
   input  logic [DATA_W-1:0] data_rd_mem,
   output logic [31:0]       cache_hit_count,
   output logic [31:0]       cache_miss_count,
   output logic [31:0]       cache_wb_count
);

   localparam int WB = $clog2(LINE_WORDS);
   localparam int IB = $clog2(SETS);
   localparam int TB = ADDR_W - 2 - WB - IB;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_EVICT,
      S_REFILL,
      S_RESPOND
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [TB-1:0]     r_tag  [2][SETS];
   logic [DATA_W-1:0] r_data [2][SETS][LINE_WORDS];
   logic [1:0][SETS-1:0] r_valid;
   logic [1:0][SETS-1:0] r_dirty;
   logic [SETS-1:0]   r_lru;

   logic              r_op_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_way;
   logic [WB-1:0]     r_word;
   logic              r_rd_mem;
   logic              r_wr_mem;
   logic [ADDR_W-1:0] r_addr_mem;
   logic [DATA_W-1:0] r_data_wr_mem;
   logic [DATA_W-1:0] r_data_rd;
   logic              r_rdy;
   logic              r_busy;
   logic [31:0]       r_hit_cnt;
   logic [31:0]       r_miss_cnt;
   logic [31:0]       r_wb_cnt;

   logic [TB-1:0] w_tag;
   logic [IB-1:0] w_idx;
   logic [WB-1:0] w_wsel;
   logic [WB-1:0] w_word_nxt;
   logic          w_hit0;
   logic          w_hit1;
   logic          w_hit;
   logic          w_victim;
   logic          w_vdirty;
   logic          w_beat_done;
   logic          w_last;

   assign w_tag  = r_addr[ADDR_W-1 -: TB];
   assign w_idx  = r_addr[2+WB +: IB];
   assign w_wsel = r_addr[2 +: WB];
   assign w_word_nxt = r_word + 1'b1;

   assign w_hit0 = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
   assign w_hit1 = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
   assign w_hit  = w_hit0 | w_hit1;

   // Prefer an empty way before consulting the LRU bit.
   assign w_victim = !r_valid[0][w_idx] ? 1'b0 :
                     !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
   assign w_vdirty = r_valid[w_victim][w_idx] &&
                     r_dirty[w_victim][w_idx];

   assign w_beat_done = (r_rd_mem | r_wr_mem) & ~busy_mem;
   assign w_last      = &r_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (rd || wr) w_state_nxt = S_LOOKUP;
         end
         S_LOOKUP: begin
            if (w_hit)         w_state_nxt = S_RESPOND;
            else if (w_vdirty) w_state_nxt = S_EVICT;
            else               w_state_nxt = S_REFILL;
         end
         S_EVICT: begin
            if (w_beat_done && w_last) w_state_nxt = S_REFILL;
         end
         S_REFILL: begin
            if (w_beat_done && w_last) w_state_nxt = S_RESPOND;
         end
         S_RESPOND: w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op_wr       <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_way         <= 1'b0;
         r_word        <= '0;
         r_rd_mem      <= 1'b0;
         r_wr_mem      <= 1'b0;
         r_addr_mem    <= '0;
         r_data_wr_mem <= '0;
         r_data_rd     <= '0;
         r_rdy         <= 1'b0;
         r_busy        <= 1'b0;
         r_hit_cnt     <= '0;
         r_miss_cnt    <= '0;
         r_wb_cnt      <= '0;
         r_valid       <= '0;
         r_dirty       <= '0;
         r_lru         <= '0;
      end else begin
         r_rdy <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (rd || wr) begin
                  r_op_wr <= wr & ~rd;
                  r_addr  <= addr_req;
                  r_wdata <= data_wr;
                  r_busy  <= 1'b1;
               end
            end
            S_LOOKUP: begin
               if (w_hit) begin
                  r_hit_cnt <= r_hit_cnt + 32'd1;
                  r_way     <= w_hit0 ? 1'b0 : 1'b1;
               end else begin
                  r_miss_cnt <= r_miss_cnt + 32'd1;
                  r_way      <= w_victim;
                  r_word     <= '0;
                  // Victim is invalid until the refill completes.
                  r_valid[w_victim][w_idx] <= 1'b0;
                  if (w_vdirty) begin
                     r_wb_cnt   <= r_wb_cnt + 32'd1;
                     r_wr_mem   <= 1'b1;
                     r_addr_mem <= {r_tag[w_victim][w_idx], w_idx,
                                    {WB{1'b0}}, 2'b00};
                     r_data_wr_mem <= r_data[w_victim][w_idx][0];
                  end else begin
                     r_rd_mem   <= 1'b1;
                     r_addr_mem <= {w_tag, w_idx, {WB{1'b0}}, 2'b00};
                  end
               end
            end
            S_EVICT: begin
               if (w_beat_done) begin
                  if (w_last) begin
                     r_wr_mem   <= 1'b0;
                     r_rd_mem   <= 1'b1;
                     r_word     <= '0;
                     r_addr_mem <= {w_tag, w_idx, {WB{1'b0}}, 2'b00};
                  end else begin
                     r_word     <= w_word_nxt;
                     r_addr_mem <= {r_tag[r_way][w_idx], w_idx,
                                    w_word_nxt, 2'b00};
                     r_data_wr_mem <= r_data[r_way][w_idx][w_word_nxt];
                  end
               end
            end
            S_REFILL: begin
               if (w_beat_done) begin
                  if (w_last) begin
                     r_rd_mem <= 1'b0;
                     r_valid[r_way][w_idx] <= 1'b1;
                     r_dirty[r_way][w_idx] <= 1'b0;
                  end else begin
                     r_word     <= w_word_nxt;
                     r_addr_mem <= {w_tag, w_idx, w_word_nxt, 2'b00};
                  end
               end
            end
            S_RESPOND: begin
               r_rdy        <= 1'b1;
               r_busy       <= 1'b0;
               r_lru[w_idx] <= ~r_way;
               if (r_op_wr) r_dirty[r_way][w_idx] <= 1'b1;
               else         r_data_rd <= r_data[r_way][w_idx][w_wsel];
            end
            default: ;
         endcase
      end
   end

   // Tag and data storage carry no reset; valid bits guard them.
   always_ff @(posedge clk) begin
      if (r_state == S_REFILL && w_beat_done) begin
         r_data[r_way][w_idx][r_word] <= data_rd_mem;
         if (w_last) r_tag[r_way][w_idx] <= w_tag;
      end
      if (r_state == S_RESPOND && r_op_wr) begin
         r_data[r_way][w_idx][w_wsel] <= r_wdata;
      end
   end

   assign data_rd          = r_data_rd;
   assign addr_resp        = r_addr;
   assign rdy              = r_rdy;
   assign busy             = r_busy;
   assign rd_mem           = r_rd_mem;
   assign wr_mem           = r_wr_mem;
   assign addr_mem         = r_addr_mem;
   assign data_wr_mem      = r_data_wr_mem;
   assign cache_hit_count  = r_hit_cnt;
   assign cache_miss_count = r_miss_cnt;
   assign cache_wb_count   = r_wb_cnt;

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl; memory returns data equal
// to the beat address and all completed beats are logged.
module tb_assoc_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] addr_req = '0;
   logic [31:0] data_wr = '0;
   logic [31:0] data_rd;
   logic [31:0] addr_resp;
   logic        rdy;
   logic        busy;
   logic        rd_mem;
   logic        wr_mem;
   logic        busy_mem = 1'b0;
   logic [31:0] addr_mem;
   logic [31:0] data_wr_mem;
   logic [31:0] data_rd_mem;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
   logic [31:0] wb_cnt;

   int checks = 0;
   int failures = 0;

   logic        log_wr [$];
   logic [31:0] log_a  [$];
   logic [31:0] log_d  [$];

   assign data_rd_mem = addr_mem;

   always #5 clk = ~clk;

   assoc_cache_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .rd               (rd),
      .wr               (wr),
      .addr_req         (addr_req),
      .data_wr          (data_wr),
      .data_rd          (data_rd),
      .addr_resp        (addr_resp),
      .rdy              (rdy),
      .busy             (busy),
      .rd_mem           (rd_mem),
      .wr_mem           (wr_mem),
      .busy_mem         (busy_mem),
      .addr_mem         (addr_mem),
      .data_wr_mem      (data_wr_mem),
      .data_rd_mem      (data_rd_mem),
      .cache_hit_count  (hit_cnt),
      .cache_miss_count (miss_cnt),
      .cache_wb_count   (wb_cnt)
   );

   always @(posedge clk) begin
      if (!rst && (rd_mem || wr_mem) && !busy_mem) begin
         log_wr.push_back(wr_mem);
         log_a.push_back(addr_mem);
         log_d.push_back(data_wr_mem);
      end
   end

   task automatic clear_log();
      log_wr.delete();
      log_a.delete();
      log_d.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      rd = 1'b0;
      wr = 1'b0;
      busy_mem = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_log();
   endtask

   task automatic req(input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] q);
      @(negedge clk);
      rd = r;
      wr = w;
      addr_req = a;
      data_wr = d;
      @(posedge clk);
      #1;
      rd = 1'b0;
      wr = 1'b0;
      lat = -1;
      q = 'x;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         if (rdy) begin
            lat = k;
            q = data_rd;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if ({busy, rdy, rd_mem, wr_mem} !== 4'b0) begin
         failures++;
         $display("FAIL reset_ctl got=%b exp=0000",
                  {busy, rdy, rd_mem, wr_mem});
      end
      checks++;
      if ({addr_mem, data_wr_mem, data_rd, addr_resp} !== 128'd0) begin
         failures++;
         $display("FAIL reset_data got=%h %h %h %h exp=0",
                  addr_mem, data_wr_mem, data_rd, addr_resp);
      end
      checks++;
      if ({hit_cnt, miss_cnt, wb_cnt} !== 96'd0) begin
         failures++;
         $display("FAIL reset_cnt got=%0d %0d %0d exp=0 0 0",
                  hit_cnt, miss_cnt, wb_cnt);
      end
   endtask

   task automatic test_cold_read();
      int lat;
      logic [31:0] q;
      do_reset();
      req(1'b1, 1'b0, 32'h120, 32'h0, lat, q);
      checks++;
      if (lat !== 6) begin
         failures++;
         $display("FAIL cold_lat got=%0d exp=6", lat);
      end
      checks++;
      if (q !== 32'h120) begin
         failures++;
         $display("FAIL cold_data got=%h exp=00000120", q);
      end
      checks++;
      if (log_a.size() !== 4) begin
         failures++;
         $display("FAIL cold_beats got=%0d exp=4", log_a.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_wr[i] !== 1'b0 || log_a[i] !== 32'h120 + 4*i) begin
               failures++;
               $display("FAIL cold_beat%0d got=%b/%h exp=0/%h",
                        i, log_wr[i], log_a[i], 32'h120 + 4*i);
            end
         end
      end
      checks++;
      if (miss_cnt !== 32'd1 || wb_cnt !== 32'd0 || hit_cnt !== 32'd0)
      begin
         failures++;
         $display("FAIL cold_cnt got=h%0d m%0d w%0d exp=h0 m1 w0",
                  hit_cnt, miss_cnt, wb_cnt);
      end
   endtask

   task automatic test_write_read_hit();
      int lat;
      logic [31:0] q;
      req(1'b0, 1'b1, 32'h124, 32'hDEADBEEF, lat, q);
      checks++;
      if (lat !== 2) begin
         failures++;
         $display("FAIL whit_lat got=%0d exp=2", lat);
      end
      req(1'b1, 1'b0, 32'h124, 32'h0, lat, q);
      checks++;
      if (lat !== 2 || q !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL rhit got=%0d/%h exp=2/deadbeef", lat, q);
      end
      checks++;
      if (log_a.size() !== 4 || hit_cnt !== 32'd2) begin
         failures++;
         $display("FAIL hit_traffic got=%0d/h%0d exp=4/h2",
                  log_a.size(), hit_cnt);
      end
   endtask

   task automatic test_lru_clean();
      int lat;
      logic [31:0] q;
      do_reset();
      req(1'b1, 1'b0, 32'h120, 32'h0, lat, q);
      req(1'b1, 1'b0, 32'h220, 32'h0, lat, q);
      checks++;
      if (lat !== 6 || q !== 32'h220) begin
         failures++;
         $display("FAIL lru_fill got=%0d/%h exp=6/00000220", lat, q);
      end
      req(1'b1, 1'b0, 32'h120, 32'h0, lat, q);
      checks++;
      if (lat !== 2) begin
         failures++;
         $display("FAIL lru_hit got=%0d exp=2", lat);
      end
      clear_log();
      req(1'b1, 1'b0, 32'h320, 32'h0, lat, q);
      checks++;
      if (lat !== 6 || log_a.size() !== 4 || log_wr[0] !== 1'b0) begin
         failures++;
         $display("FAIL lru_repl got=%0d/%0d exp=6/4", lat, log_a.size());
      end
      req(1'b1, 1'b0, 32'h128, 32'h0, lat, q);
      checks++;
      if (lat !== 2 || q !== 32'h128) begin
         failures++;
         $display("FAIL lru_keep got=%0d/%h exp=2/00000128", lat, q);
      end
      req(1'b1, 1'b0, 32'h220, 32'h0, lat, q);
      checks++;
      if (lat !== 6 || wb_cnt !== 32'd0) begin
         failures++;
         $display("FAIL lru_gone got=%0d/w%0d exp=6/w0", lat, wb_cnt);
      end
   endtask

   task automatic test_dirty_evict();
      int lat;
      logic [31:0] q;
      logic [31:0] ea [8];
      logic [31:0] ed [4];
      do_reset();
      req(1'b0, 1'b1, 32'h124, 32'hDEADBEEF, lat, q);
      req(1'b1, 1'b0, 32'h220, 32'h0, lat, q);
      clear_log();
      req(1'b1, 1'b0, 32'h320, 32'h0, lat, q);
      for (int i = 0; i < 4; i++) begin
         ea[i] = 32'h120 + 4*i;
         ea[i+4] = 32'h320 + 4*i;
         ed[i] = ea[i];
      end
      ed[1] = 32'hDEADBEEF;
      checks++;
      if (lat !== 10 || q !== 32'h320) begin
         failures++;
         $display("FAIL dirty_lat got=%0d/%h exp=10/00000320", lat, q);
      end
      checks++;
      if (log_a.size() !== 8) begin
         failures++;
         $display("FAIL dirty_beats got=%0d exp=8", log_a.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_a[i] !== ea[i] || log_wr[i] !== (i < 4) ||
                (i < 4 && log_d[i] !== ed[i])) begin
               failures++;
               $display("FAIL dirty_beat%0d got=%b/%h/%h exp=%b/%h",
                        i, log_wr[i], log_a[i], log_d[i], i < 4, ea[i]);
            end
         end
      end
      checks++;
      if (wb_cnt !== 32'd1 || miss_cnt !== 32'd3) begin
         failures++;
         $display("FAIL dirty_cnt got=w%0d m%0d exp=w1 m3",
                  wb_cnt, miss_cnt);
      end
   endtask

   task automatic test_stall();
      int lat;
      logic [31:0] q;
      bit found;
      do_reset();
      found = 0;
      fork
         req(1'b1, 1'b0, 32'h120, 32'h0, lat, q);
         begin
            for (int n = 0; n < 50; n++) begin
               @(negedge clk);
               if (rd_mem && addr_mem == 32'h128) begin
                  found = 1;
                  break;
               end
            end
            if (found) begin
               busy_mem = 1'b1;
               for (int s = 0; s < 3; s++) begin
                  @(posedge clk);
                  #1;
                  checks++;
                  if (rd_mem !== 1'b1 || addr_mem !== 32'h128) begin
                     failures++;
                     $display("FAIL stall_hold%0d got=%b/%h exp=1/128",
                              s, rd_mem, addr_mem);
                  end
               end
               @(negedge clk);
               busy_mem = 1'b0;
            end
         end
      join
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL stall_seen got=0 exp=1");
      end
      checks++;
      if (lat !== 9 || q !== 32'h120) begin
         failures++;
         $display("FAIL stall_lat got=%0d/%h exp=9/00000120", lat, q);
      end
   endtask

   task automatic test_reset_mid_and_rdwr();
      int lat;
      logic [31:0] q;
      bit found;
      do_reset();
      found = 0;
      @(negedge clk);
      rd = 1'b1;
      addr_req = 32'h120;
      @(posedge clk);
      #1;
      rd = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (rd_mem && addr_mem == 32'h128) begin
            found = 1;
            break;
         end
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (!found || rd_mem !== 1'b0 || busy !== 1'b0 ||
          addr_mem !== 32'h0 || miss_cnt !== 32'd0) begin
         failures++;
         $display("FAIL rst_mid got=%0b/%b/%b/%h/m%0d exp=1/0/0/0/m0",
                  found, rd_mem, busy, addr_mem, miss_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      clear_log();
      req(1'b1, 1'b0, 32'h120, 32'h0, lat, q);
      checks++;
      if (lat !== 6 || miss_cnt !== 32'd1 || log_a.size() !== 4) begin
         failures++;
         $display("FAIL rst_reread got=%0d/m%0d/%0d exp=6/m1/4",
                  lat, miss_cnt, log_a.size());
      end
      req(1'b1, 1'b1, 32'h124, 32'h55, lat, q);
      checks++;
      if (lat !== 2 || q !== 32'h124) begin
         failures++;
         $display("FAIL rdwr_read got=%0d/%h exp=2/00000124", lat, q);
      end
      req(1'b1, 1'b0, 32'h124, 32'h0, lat, q);
      checks++;
      if (q !== 32'h124) begin
         failures++;
         $display("FAIL rdwr_data got=%h exp=00000124", q);
      end
      req(1'b1, 1'b0, 32'h220, 32'h0, lat, q);
      clear_log();
      req(1'b1, 1'b0, 32'h320, 32'h0, lat, q);
      checks++;
      if (lat !== 6 || wb_cnt !== 32'd0 || log_wr[0] !== 1'b0) begin
         failures++;
         $display("FAIL rdwr_clean got=%0d/w%0d exp=6/w0", lat, wb_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_cold_read();
      test_write_read_hit();
      test_lru_clean();
      test_dirty_evict();
      test_stall();
      test_reset_mid_and_rdwr();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
